sin_poly_seq: RTL and testbench
===============================

# sin_poly_seq

Multi-cycle sequencer that evaluates sin(x) for x in [0, π/2] with the order-2 segmented polynomial datapath in the SFU. It drives the sine coefficient LUT with the top 12 bits of the angle. It then time-shares one signed 25x17 multiplier across the two Horner steps of y = c0 + t·(c1 + c2·t), where t = x − a. A valid/ready handshake sits on both input and output.

## Interface
Parameters: none. Formats are fixed by the coefficient LUT.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  angle available
- in_ready  output  1  block accepts angle this cycle
- in_x  input  16  unsigned angle, Q2.14 radians
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_y  output  29  signed sin(x), Q3.26
- out_range_err  output  1  in_x[15:4] > 1608; travels with out_y
- lut_x_msb  output  12  to LUT x_msb; equals latched in_x[15:4]
- lut_c0 / lut_c1 / lut_c2 / lut_a  input  29/25/17/14  signed LUT outputs
  - c0: Q.26
  - c1: Q.23
  - c2: Q.15
  - a: unsigned-valued, Q.11

## Operation
- States: IDLE, LOOK, MUL1, MUL2, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- **Accept** (in_valid & in_ready):
  - latch in_x into x_r; lut_x_msb = x_r[15:4]
  - go to LOOK
- **LOOK**:
  - register c0_r, c1_r, c2_r
  - t_r = {2'b0,x_r} − {1'b0,lut_a,3'b0}, 18-bit signed, then truncated to 17 bits signed
  - err_r = (x_r[15:4] > 1608)
  - go to MUL1
- **MUL1**:
  - mul_a = sign-extended c2_r, mul_b = t_r
  - acc_r = c1_r + (prod >>> 6), computed at 26 bits and truncated to 25
  - go to MUL2
- **MUL2**:
  - mul_a = acc_r, mul_b = t_r
  - y_r = c0_r + (prod >>> 11), truncated to 29 bits
  - if err_r, y_r = 29'h400_0000 (1.0) instead
  - go to DONE
- **DONE**:
  - out_valid=1; out_y=y_r and out_range_err=err_r, both held stable
  - on out_ready & !in_valid, go to IDLE
  - on out_ready & in_valid, accept the new angle and go to LOOK (back-to-back)
- The multiplier has exactly one instance; the product is combinational, 42-bit signed.
- Shifts are arithmetic. Truncation toward −∞ unless rounding is enabled (see Configuration).

## Timing
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0
  - out_y=0; out_range_err=0; lut_x_msb=0
  - all internal registers 0
- Latency: accept at edge N gives out_valid=1 from edge N+4.
- Throughput: one result per 4 cycles with out_ready held high.
- out_valid stays high and out_y stays stable while out_ready=0; there is no drop and no overwrite.
- in_valid with in_ready=0: no effect. The producer holds in_x.
- Reset asserted mid-operation aborts immediately to the reset values. The in-flight result is lost and no out_valid pulse occurs.
- x_msb boundaries:
  - 1608 is in range.
  - 1609..4095 set out_range_err=1 with y forced to 1.0.

## Configuration
- SIN_POLY_SEQ_ROUND_EN
  - Defined: both right shifts round to nearest. Add 2^5 before >>>6 and 2^10 before >>>11, ties toward +∞.
  - Undefined: plain truncating arithmetic shift.
  - Latency and interface are identical either way.

## Test plan
- Reset, then in_x=16'h0000 with out_ready=1:
  - handshake at edge N, out_valid at N+4
  - |out_y| ≤ 16 LSB; out_range_err=0
- in_x=16'h6488 (≈π/2, x_msb=1608):
  - out_y within 64 LSB of 29'h400_0000
  - out_range_err=0
- in_x=16'h6490 (x_msb=1609):
  - out_range_err=1; out_y=29'h400_0000 exactly
- in_x=16'h2183 (≈π/6):
  - out_y within 64 LSB of 29'h200_0000 (0.5)
- Back-pressure, then back-to-back:
  - out_ready=0 for 10 cycles: out_valid and out_y held; in_ready=0
  - then out_ready=1 with in_valid=1: new angle accepted in the same cycle
  - next out_valid exactly 4 cycles later
- Reset mid-operation:
  - rst_n low during MUL1 gives out_valid=0, in_ready=1 after release
  - next transaction produces the correct result
- All scenarios pass with SIN_POLY_SEQ_ROUND_EN both defined and undefined.

Source files
------------

// File: rtl/sin_poly_seq.sv
// sin(x) on [0, pi/2] via LUT + order-2 Horner, one shared 25x17 multiplier; SIN_POLY_SEQ_ROUND_EN selects round-to-nearest shifts.
// Latency: accept at edge N, out_valid seen by the consumer at edge N+4; throughput one result per 4 cycles.
// Backpressure: result held in DONE until out_ready; a new angle is taken in the same cycle the result leaves.
module sin_poly_seq (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [28:0] out_y,
    output logic               out_range_err,
    output logic [11:0]        lut_x_msb,
    input  logic signed [28:0] lut_c0,
    input  logic signed [24:0] lut_c1,
    input  logic signed [16:0] lut_c2,
    input  logic [13:0]        lut_a
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOOK = 3'd1,
        S_MUL1 = 3'd2,
        S_MUL2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

`ifdef SIN_POLY_SEQ_ROUND_EN
    localparam logic signed [41:0] RND6  = 42'sd32;
    localparam logic signed [41:0] RND11 = 42'sd1024;
`else
    localparam logic signed [41:0] RND6  = 42'sd0;
    localparam logic signed [41:0] RND11 = 42'sd0;
`endif

    state_t              state_q, state_d;
    logic                accept;
    logic [15:0]         x_q;
    logic signed [28:0]  c0_q;
    logic signed [24:0]  c1_q;
    logic signed [16:0]  c2_q;
    logic signed [16:0]  t_q, t_d;
    logic                err_q, err_d;
    logic signed [24:0]  acc_q, acc_d;
    logic signed [28:0]  y_q, y_d;

    logic signed [24:0]  mul_a;
    logic signed [16:0]  mul_b;
    logic signed [41:0]  prod;
    logic signed [41:0]  sh6, sh11;
    logic [17:0]         t_diff;
    logic [25:0]         acc_sum;
    logic [28:0]         y_sum;
    logic                unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOOK;
            S_LOOK:  state_d = S_MUL1;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = in_valid ? S_LOOK : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
        out_valid = (state_q == S_DONE);
        mul_a     = acc_q;
        if (state_q == S_MUL1) begin
            mul_a = {{8{c2_q[16]}}, c2_q};
        end
    end

    assign accept = in_valid & in_ready;
    assign mul_b  = t_q;

    // The single multiplier: c2*t in MUL1, acc*t in MUL2.
    assign prod = $signed({{17{mul_a[24]}}, mul_a}) * $signed({{25{mul_b[16]}}, mul_b});
    assign sh6  = (prod + RND6) >>> 6;
    assign sh11 = (prod + RND11) >>> 11;

    // Segment start a is Q.11; shifting by 3 aligns it to the Q2.14 angle.
    assign t_diff  = {2'b00, x_q} - {1'b0, lut_a, 3'b000};
    assign t_d     = $signed(t_diff[16:0]);
    assign err_d   = (x_q[15:4] > 12'd1608);
    assign acc_sum = {c1_q[24], c1_q} + sh6[25:0];
    assign acc_d   = $signed(acc_sum[24:0]);
    assign y_sum   = c0_q + sh11[28:0];
    assign y_d     = err_q ? 29'sh400_0000 : $signed(y_sum);

    assign unused_bits = ^{t_diff[17], sh6[41:26], sh11[41:29], acc_sum[25]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            c0_q  <= '0;
            c1_q  <= '0;
            c2_q  <= '0;
            t_q   <= '0;
            err_q <= 1'b0;
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            if (accept) begin
                x_q <= in_x;
            end
            if (state_q == S_LOOK) begin
                c0_q  <= lut_c0;
                c1_q  <= lut_c1;
                c2_q  <= lut_c2;
                t_q   <= t_d;
                err_q <= err_d;
            end
            if (state_q == S_MUL1) begin
                acc_q <= acc_d;
            end
            if (state_q == S_MUL2) begin
                y_q <= y_d;
            end
        end
    end

    assign out_y         = y_q;
    assign out_range_err = err_q;
    assign lut_x_msb     = x_q[15:4];

endmodule

// File: tb/tb_sin_poly_seq.sv
// Bench for sin_poly_seq: LUT model with real sin/cos, scoreboard of expected results, decoupled output monitor.
module tb_sin_poly_seq;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_x;
    logic               out_valid;
    logic               out_ready;
    logic signed [28:0] out_y;
    logic               out_range_err;
    logic [11:0]        lut_x_msb;
    logic signed [28:0] lut_c0;
    logic signed [24:0] lut_c1;
    logic signed [16:0] lut_c2;
    logic [13:0]        lut_a;

    typedef struct {
        logic [15:0] x;
        bit          err;
        longint      y;
        int          acc_cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    bit     rdy_rand = 0;
    bit     rdy_force = 1;
    bit     presenting = 0;
    longint held_y = 0;
    bit     held_e = 0;

    sin_poly_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_y         (out_y),
        .out_range_err (out_range_err),
        .lut_x_msb     (lut_x_msb),
        .lut_c0        (lut_c0),
        .lut_c1        (lut_c1),
        .lut_c2        (lut_c2),
        .lut_a         (lut_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    // ---------------- coefficient LUT: Taylor expansion about segment start ----------------
    function automatic longint qround(input real r);
        return longint'($floor(r + 0.5));
    endfunction

    function automatic real seg_a(input int m);
        return real'(m) * 2.0 / 2048.0;
    endfunction

    function automatic longint c0v(input int m);
        return qround($sin(seg_a(m)) * 67108864.0);
    endfunction

    function automatic longint c1v(input int m);
        return qround($cos(seg_a(m)) * 8388608.0);
    endfunction

    function automatic longint c2v(input int m);
        return qround(-$sin(seg_a(m)) * 0.5 * 32768.0);
    endfunction

    always_comb begin
        lut_c0 = 29'(c0v(int'(lut_x_msb)));
        lut_c1 = 25'(c1v(int'(lut_x_msb)));
        lut_c2 = 17'(c2v(int'(lut_x_msb)));
        lut_a  = {1'b0, lut_x_msb, 1'b0};
    end

    // ---------------- reference model ----------------
    function automatic longint sext(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint shr(input longint p, input int s);
`ifdef SIN_POLY_SEQ_ROUND_EN
        return (p + (longint'(1) << (s - 1))) >>> s;
`else
        return p >>> s;
`endif
    endfunction

    function automatic exp_t model(input logic [15:0] x);
        exp_t   e;
        int     m;
        longint t, acc;
        m   = int'(x[15:4]);
        t   = sext(longint'(x) - longint'(m * 2) * 8, 17);
        acc = sext(c1v(m) + shr(c2v(m) * t, 6), 25);
        e.x = x;
        e.err = (m > 1608);
        e.y = e.err ? (longint'(1) << 26) : sext(c0v(m) + shr(acc * t, 11), 29);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // ---------------- out_ready generator ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t e;
        real  r;
        real  d;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            presenting = 0;
        end else if (out_valid) begin
            if (!presenting) begin
                presenting = 1;
                held_y = longint'(out_y);
                held_e = out_range_err;
                if (sb.size() == 0) check(1'b0, "unexpected_out", longint'(out_y), 0);
                else check(cyc == sb[0].acc_cyc + 4, "latency", cyc, sb[0].acc_cyc + 4);
            end else begin
                check(longint'(out_y) == held_y && out_range_err == held_e, "hold", longint'(out_y), held_y);
            end
            if (out_ready) begin
                presenting = 0;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check(longint'(out_y) == e.y, "y_exact", longint'(out_y), e.y);
                    check(out_range_err == e.err, "range_err", longint'(out_range_err), longint'(e.err));
                    if (!e.err) begin
                        r = $sin(real'(e.x) / 16384.0) * 67108864.0;
                        d = real'(out_y) - r;
                        if (d < 0.0) d = -d;
                        check(d <= ((e.x == 16'h0000) ? 16.0 : 64.0), "accuracy", longint'(out_y), qround(r));
                    end
                end
            end
        end else if (presenting) begin
            check(1'b0, "dropped_out", 0, 1);
            presenting = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] x);
        bit   got;
        exp_t e;
        got = 0;
        in_x = x;
        in_valid = 1'b1;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge clk);
            got = in_ready;
        end
        check(got, "accept_timeout", longint'(got), 1);
        if (got) begin
            e = model(x);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            done = (sb.size() == 0);
        end
        check(done, "drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check(seen, "valid_timeout", longint'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] xr;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(in_ready == 1'b1, "rst_in_ready", longint'(in_ready), 1);
        check(out_valid == 1'b0, "rst_out_valid", longint'(out_valid), 0);
        check(out_y == 29'sd0, "rst_out_y", longint'(out_y), 0);
        check(out_range_err == 1'b0, "rst_range_err", longint'(out_range_err), 0);
        check(lut_x_msb == 12'd0, "rst_lut_x_msb", longint'(lut_x_msb), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed angles and x_msb boundaries.
        send(16'h0000);  drain(50);
        send(16'h6488);  drain(50);
        send(16'h648F);  drain(50);
        send(16'h6490);  drain(50);
        send(16'h2183);  drain(50);
        send(16'hFFFF);  drain(50);

        // Back-pressure for 10 cycles, then back-to-back accept.
        rdy_force = 1'b0;
        send(16'h1000);
        wait_valid(20);
        in_x = 16'h3000;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check(in_ready == 1'b0, "bp_in_ready", longint'(in_ready), 0);
            check(out_valid == 1'b1, "bp_out_valid", longint'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b1;
        send(16'h3000);
        drain(50);

        // Reset during MUL1 discards the in-flight result.
        send(16'h1234);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "midrst_out_valid", longint'(out_valid), 0);
        check(in_ready == 1'b1, "midrst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check(out_valid == 1'b0, "postrst_out_valid", longint'(out_valid), 0);
            check(in_ready == 1'b1, "postrst_in_ready", longint'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        send(16'h1234);
        drain(50);

        // Randomised traffic with random consumer stalls.
        rdy_rand = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 7) == 0) xr = 16'($urandom_range(0, 65535));
            else xr = 16'($urandom_range(0, 16'h6500));
            send(xr);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain(3000);
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
